mem_bus_rx: RTL

Memory-side endpoint of the narrow cache/buffer-to-memory bus. It accepts a serialized transfer from a bus sender: address beats, then data beats for writes only. It reassembles the transfer into a full request and queues it in a small FIFO. A ready/valid interface presents queued requests to the data memory, and a one-cycle done pulse tells the sender that the transfer has been accepted.

---
 rtl/mem_bus_rx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_rx.sv
// Memory-side endpoint of the narrow bus: reassembles serialized address/data beats into a
// request and queues it in a small FIFO presented to the data memory over ready/valid.
module mem_bus_rx #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned BUS_W  = 8,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     send,
   input  logic                     write_in,
   input  logic [BUS_W-1:0]         bus,
   output logic                     rx_ready,
   output logic                     done,
   output logic                     req_valid,
   output logic                     req_write,
   output logic [ADDR_W-1:0]        req_addr,
   output logic [DATA_W-1:0]        req_data,
   input  logic                     req_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned NA   = ADDR_W / BUS_W;
   localparam int unsigned ND   = DATA_W / BUS_W;
   localparam int unsigned MaxB = (NA > ND) ? NA : ND;
   localparam int unsigned CW   = $clog2(MaxB) + 1;
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned NW   = PW + 1;
   localparam logic [CW-1:0] LastA = CW'(NA - 1);
   localparam logic [CW-1:0] LastD = CW'(ND - 1);
   localparam logic [NW-1:0] Full  = NW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StAddr, StData, StPush} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       beat_q;
   logic                type_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                rx_ready_q, done_q;
   logic                accept, push, pop;
   logic [NW-1:0]       count_q, count_d;
   logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
   logic                mem_type [DEPTH];
   logic [ADDR_W-1:0]   mem_addr [DEPTH];
   logic [DATA_W-1:0]   mem_data [DEPTH];

   assign accept = send && rx_ready_q;
   assign push   = (state_q == StPush);
   assign pop    = (count_q != '0) && req_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (NA == 1) state_d = write_in ? StData : StPush;
               else         state_d = StAddr;
            end
         end
         StAddr: if (accept && beat_q == LastA) state_d = type_q ? StData : StPush;
         StData: if (accept && beat_q == LastD) state_d = StPush;
         StPush: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   // rx_ready is registered, so it is derived from next state and next occupancy.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         beat_q     <= '0;
         type_q     <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         rx_ready_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_q     <= (state_d == StPush);
         rx_ready_q <= (state_d == StIdle) ? (count_d < Full)
                                           : (state_d == StAddr || state_d == StData);
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  type_q             <= write_in;
                  addr_q[BUS_W-1:0]  <= bus;
                  beat_q             <= (NA == 1) ? '0 : CW'(1);
                  if (NA == 1 && !write_in) data_q <= '0;
               end
            end
            StAddr: begin
               if (accept) begin
                  addr_q[beat_q*BUS_W +: BUS_W] <= bus;
                  if (beat_q == LastA) begin
                     beat_q <= '0;
                     if (!type_q) data_q <= '0;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end
            StData: begin
               if (accept) begin
                  data_q[beat_q*BUS_W +: BUS_W] <= bus;
                  beat_q <= (beat_q == LastD) ? '0 : beat_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_type[wr_ptr_q] <= type_q;
         mem_addr[wr_ptr_q] <= addr_q;
         mem_data[wr_ptr_q] <= data_q;
      end
   end

   assign rx_ready  = rx_ready_q;
   assign done      = done_q;
   assign count     = count_q;
   assign req_valid = (count_q != '0);
   assign req_write = req_valid && mem_type[rd_ptr_q];
   assign req_addr  = req_valid ? mem_addr[rd_ptr_q] : '0;
   assign req_data  = req_valid ? mem_data[rd_ptr_q] : '0;

endmodule
